// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between an upstream byte fifo and the UART transmitter.
// master: the transmitter issuing reads; slave: the fifo answering them.
interface fifo_uart_tx_if;
    logic       fifo_empty;
    logic [7:0] fifo_read_data;
    logic       fifo_read_enable;

    modport master (
        input  fifo_empty,
        input  fifo_read_data,
        output fifo_read_enable
    );

    modport slave (
        output fifo_empty,
        output fifo_read_data,
        input  fifo_read_enable
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Fifo-fed 8N1 UART transmitter: pulls one byte per frame, shifts it out LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_uart_tx_if.master       fifo,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done,
    output logic [15:0]          frames_sent
);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
    } state_e;

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        tx_q, tx_d;
    logic [15:0] frames_q;
    logic        bit_end;

`ifdef UART_TX_PARITY_EN
    logic        parity_q;
`endif

    assign bit_end     = (cnt_q == LAST_CNT);
    assign tx          = tx_q;
    assign frames_sent = frames_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            tx_q     <= 1'b1;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            tx_q     <= tx_d;
            if (frame_done)
                frames_q <= frames_q + 16'd1;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            parity_q <= 1'b0;
        else if (state_q == LOAD)
            parity_q <= ^fifo.fifo_read_data;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        case (state_q)
            IDLE:  if (!fifo.fifo_empty) state_d = FETCH;
            FETCH: state_d = LOAD;
            LOAD: begin
                // Read data arrives one cycle after the FETCH request.
                sh_d    = fifo.fifo_read_data;
                cnt_d   = '0;
                bit_d   = '0;
                state_d = START;
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    sh_d  = {1'b0, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx_d follows the next state so the registered line lines up with state_q.
    always_comb begin
        fifo.fifo_read_enable = 1'b0;
        busy                  = (state_q != IDLE);
        frame_done            = 1'b0;
        tx_d                  = 1'b1;
        case (state_q)
            FETCH:   fifo.fifo_read_enable = 1'b1;
            STOP:    frame_done = bit_end;
            default: ;
        endcase
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4 with a small fifo model.
// Follows UART_TX_PARITY_EN to choose the expected frame length.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tx, busy, frame_done;
    logic [15:0] frames_sent;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rd_cnt  = 0;

    logic [7:0] mem [16];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [7:0] rd_data = 8'h00;

    fifo_uart_tx_if fifo_if ();

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo        (fifo_if.master),
        .tx          (tx),
        .busy        (busy),
        .frame_done  (frame_done),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    assign fifo_if.fifo_empty     = (wr_ptr == rd_ptr);
    assign fifo_if.fifo_read_data = rd_data;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_if.fifo_read_enable) begin
            rd_cnt <= rd_cnt + 1;
            if (wr_ptr != rd_ptr) begin
                rd_data <= mem[rd_ptr % 16];
                rd_ptr  <= rd_ptr + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 16] = b;
        wr_ptr++;
    endtask

    // Call at a negedge; returns the cycle of the first start sample and of frame_done.
    task automatic expect_frame(input string tag, input logic [7:0] b,
                                output int start_c, output int done_c);
        logic [10:0] exp;
        int errs, dones, w;
`ifdef UART_TX_PARITY_EN
        exp = {1'b1, ^b, b, 1'b0};
`else
        exp = {2'b11, b, 1'b0};
`endif
        start_c = 0;
        done_c  = 0;
        w = 0;
        while (tx !== 1'b0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (tx !== 1'b0) begin
            chk({tag, " start timeout"}, 32'(tx), 32'd0);
            return;
        end
        start_c = cyc;
        errs = 0;
        dones = 0;
        for (int k = 0; k < NB * CPB; k++) begin
            if (k > 0) @(negedge clk);
            if (tx !== exp[k / CPB]) errs++;
            if (frame_done === 1'b1) begin
                dones++;
                done_c = cyc;
            end
        end
        chk({tag, " bits"}, 32'(errs), 32'd0);
        chk({tag, " done pulses"}, 32'(dones), 32'd1);
        chk({tag, " length"}, 32'(done_c - start_c + 1), 32'(NB * CPB));
    endtask

    initial begin
        int s0, d0, s1, d1, bad_rd, bad_tx, bad_busy, rd0;

        repeat (3) @(negedge clk);
        chk("rst tx", 32'(tx), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst rd_en", 32'(fifo_if.fifo_read_enable), 32'd0);
        chk("rst done", 32'(frame_done), 32'd0);
        chk("rst frames", 32'(frames_sent), 32'd0);
        reset = 1'b0;

        // Empty fifo: the transmitter must stay completely quiet.
        bad_rd = 0; bad_tx = 0; bad_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fifo_if.fifo_read_enable !== 1'b0) bad_rd++;
            if (tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
        end
        chk("idle rd_en", 32'(bad_rd), 32'd0);
        chk("idle tx", 32'(bad_tx), 32'd0);
        chk("idle busy", 32'(bad_busy), 32'd0);

        // Single byte 0xA5.
        push(8'hA5);
        expect_frame("A5", 8'hA5, s0, d0);
        @(negedge clk);
        chk("A5 frames", 32'(frames_sent), 32'd1);
        chk("A5 reads", 32'(rd_cnt), 32'd1);
        chk("A5 idle busy", 32'(busy), 32'd0);

        // Back-to-back bytes: 3 idle-high cycles between stop end and next start.
        rd0 = rd_cnt;
        push(8'h00);
        push(8'hFF);
        expect_frame("00", 8'h00, s0, d0);
        expect_frame("FF", 8'hFF, s1, d1);
        chk("gap cycles", 32'(s1 - d0 - 1), 32'd3);
        repeat (10) @(negedge clk);
        chk("pair reads", 32'(rd_cnt - rd0), 32'd2);
        chk("pair frames", 32'(frames_sent), 32'd3);

        // Reset while data bit 3 is on the line.
        push(8'h3C);
        s0 = 0;
        while (tx !== 1'b0 && s0 < 300) begin
            @(negedge clk);
            s0++;
        end
        repeat (4 * CPB + 1) @(negedge clk);
        chk("pre-rst busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst tx", 32'(tx), 32'd1);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst frames", 32'(frames_sent), 32'd0);
        push(8'h96);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post-rst rd_en", 32'(fifo_if.fifo_read_enable), 32'd0);
        @(negedge clk);
        chk("post-rst fetch", 32'(fifo_if.fifo_read_enable), 32'd1);
        expect_frame("96", 8'h96, s0, d0);
        @(negedge clk);
        chk("96 frames", 32'(frames_sent), 32'd1);

        // Counter rollover.
        force dut.frames_q = 16'hFFFF;
        @(negedge clk);
        release dut.frames_q;
        chk("preload", 32'(frames_sent), 32'hFFFF);
        push(8'h07);
        expect_frame("07", 8'h07, s0, d0);
        @(negedge clk);
        chk("wrap frames", 32'(frames_sent), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
